// File: rtl/barrel_shift_seq.sv
// Multi-pass sequencer for a 3-bit-count barrel shifter: splits a shift of up to
// 2^AMT_W-1 positions into passes of at most 7 and loops the word through the shifter.
module barrel_shift_seq #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic [AMT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] sh_data,
   output logic [2:0]       sh_number,
   output logic             sh_sll,
   output logic             sh_srl,
   output logic             sh_sra,
   input  logic [WIDTH-1:0] sh_result
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_PASS = 2'b11
   } op_t;

   state_t           state;
   op_t              op_q;
   logic [WIDTH-1:0] acc;
   logic [AMT_W-1:0] rem;
   logic [2:0]       step;
   logic [AMT_W-1:0] rem_next;

   // Every pass but the last moves the full 7 positions, so rem can never underflow.
   always_comb begin
      step     = (rem > AMT_W'(7)) ? 3'd7 : rem[2:0];
      rem_next = rem - AMT_W'(step);
   end

   assign busy    = (state != IDLE);
   assign sh_data = acc;

   // NOTE: every output of a combinational block gets a default first, so no path
   // through the case can leave a value unassigned and infer a latch.
   always_comb begin
      sh_number = 3'd0;
      sh_sll    = 1'b0;
      sh_srl    = 1'b0;
      sh_sra    = 1'b0;
      if (state == SHIFT) begin
         sh_number = step;
         case (op_q)
            OP_SLL:  sh_sll = 1'b1;
            OP_SRL:  sh_srl = 1'b1;
            OP_SRA:  sh_sra = 1'b1;
            OP_PASS: ;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= OP_SLL;
         acc    <= '0;
         rem    <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc  <= operand;
                  rem  <= amount;
                  op_q <= op_t'(op);
                  if (amount == '0 || op_t'(op) == OP_PASS) begin
                     state  <= DONE;
                     result <= operand;
                     done   <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc <= sh_result;
               rem <= rem_next;
               // result is loaded with the value acc takes in DONE, so it is valid with done.
               if (rem_next == '0) begin
                  state  <= DONE;
                  result <= sh_result;
                  done   <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Directed bench for barrel_shift_seq: a behavioural shifter closes the loop and a
// result queue holds the expected word of each request until its done pulse.
module tb_barrel_shift_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand;
   logic [4:0]  amount;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] sh_data;
   logic [2:0]  sh_number;
   logic        sh_sll;
   logic        sh_srl;
   logic        sh_sra;
   logic [31:0] sh_result;

   int          errors   = 0;
   int          n_checks = 0;
   int          done_cnt = 0;
   int          n_req    = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   barrel_shift_seq #(.WIDTH(32), .AMT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .operand   (operand),
      .amount    (amount),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .sh_data   (sh_data),
      .sh_number (sh_number),
      .sh_sll    (sh_sll),
      .sh_srl    (sh_srl),
      .sh_sra    (sh_sra),
      .sh_result (sh_result)
   );

   // Board shifter: combinational, owns the fill behaviour.
   always_comb begin
      sh_result = sh_data;
      if (sh_sll)      sh_result = sh_data << sh_number;
      else if (sh_srl) sh_result = sh_data >> sh_number;
      else if (sh_sra) sh_result = 32'($signed(sh_data) >>> sh_number);
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check(32'(busy), 32'd0, {tag, " busy"});
      check(32'(done), 32'd0, {tag, " done"});
      check(32'(sh_number), 32'd0, {tag, " sh_number"});
      check(32'({sh_sll, sh_srl, sh_sra}), 32'd0, {tag, " selects"});
   endtask

   // Called right after a negedge; returns at the negedge of cycle P+2.
   task automatic run_req(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a,
                          input logic [31:0] exp_res, input bit poke, input string tag);
      int p;
      int last;
      p    = (a == 5'd0 || o == 2'b11) ? 0 : (int'(a) + 6) / 7;
      last = int'(a) - 7 * (p - 1);
      n_req++;
      exp_q.push_back(exp_res);
      start   = 1'b1;
      op      = o;
      operand = d;
      amount  = a;
      for (int k = 1; k <= p + 1; k++) begin
         @(negedge clk);
         start = poke && (k == 1 || k == p + 1);
         if (start) begin
            op      = 2'b01;
            operand = 32'hDEAD_BEEF;
            amount  = 5'd3;
         end
         check(32'(busy), 32'd1, $sformatf("%s busy c%0d", tag, k));
         if (k <= p) begin
            check(32'(sh_number), (k < p) ? 32'd7 : 32'(last), $sformatf("%s sh_number c%0d", tag, k));
            check(32'({sh_sll, sh_srl, sh_sra}), 32'({o == 2'b00, o == 2'b01, o == 2'b10}),
                  $sformatf("%s selects c%0d", tag, k));
            check(32'(done), 32'd0, $sformatf("%s early done c%0d", tag, k));
            if (k == 1) check(sh_data, d, {tag, " sh_data c1"});
         end else begin
            check(32'(done), 32'd1, $sformatf("%s done c%0d", tag, k));
            check(32'(sh_number), 32'd0, {tag, " sh_number in DONE"});
            check(32'({sh_sll, sh_srl, sh_sra}), 32'd0, {tag, " selects in DONE"});
            check(32'(exp_q.size()), 32'd1, {tag, " scoreboard depth"});
            if (exp_q.size() != 0) check(result, exp_q.pop_front(), {tag, " result"});
         end
      end
      @(negedge clk);
      start = 1'b0;
      check_idle_outputs({tag, " first idle"});
      check(result, exp_res, {tag, " result held"});
   endtask

   initial begin
      // A start presented during reset must be dropped.
      rst     = 1'b1;
      start   = 1'b1;
      op      = 2'b00;
      operand = 32'h0000_0001;
      amount  = 5'd10;
      @(negedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check(result, 32'h0, "reset result");
      check(sh_data, 32'h0, "reset sh_data");
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check(32'(busy), 32'd0, "start in reset dropped");

      run_req(2'b00, 32'h0000_0001, 5'd10, 32'h0000_0400, 1'b0, "sll10");
      run_req(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, "sra31");
      run_req(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, "srl31");
      run_req(2'b00, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0, "zero_amt");
      run_req(2'b11, 32'hA5A5_A5A5, 5'd5,  32'hA5A5_A5A5, 1'b0, "pass");
      run_req(2'b00, 32'h0000_0003, 5'd14, 32'h0000_C000, 1'b1, "busy_start");
      run_req(2'b01, 32'hF000_0000, 5'd20, 32'h0000_0F00, 1'b0, "b2b_srl20");
      run_req(2'b10, 32'h7F00_0000, 5'd8,  32'h007F_0000, 1'b0, "sra8_pos");

      // Reset in cycle 2 of an sra-by-20 aborts it without a done pulse.
      start   = 1'b1;
      op      = 2'b10;
      operand = 32'h8000_0000;
      amount  = 5'd20;
      @(negedge clk);
      start = 1'b0;
      check(32'(busy), 32'd1, "abort busy c1");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("abort c3");
      check(result, 32'h0, "abort result");
      check(sh_data, 32'h0, "abort sh_data");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check(32'(done), 32'd0, $sformatf("abort no done +%0d", i));
      end

      run_req(2'b10, 32'h8000_0000, 5'd20, 32'hFFFF_F800, 1'b0, "post_abort_sra20");
      run_req(2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b0, "sll4");

      repeat (3) @(negedge clk);
      check(32'(done_cnt), 32'(n_req), "done pulse count");
      check(32'(exp_q.size()), 32'd0, "scoreboard drained");

      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule

// File: doc/barrel_shift_seq.md
# barrel_shift_seq

Multi-pass sequencer for the board barrel shifter. The shifter datapath moves at most 7 bit positions per evaluation because its shift-count field is 3 bits wide. This block accepts one shift request of up to 31 positions, splits it into passes of at most 7, feeds each intermediate result back through the shifter, and returns the final word with a done pulse. It sits between the board input logic and the shifter instance and owns all of the shifter's control inputs.

## Interface

Parameters:
- `WIDTH`, 32: operand/result width; must match the shifter data width.
- `AMT_W`, 5: request shift-amount width (maximum amount 2^AMT_W-1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 = sll, 01 = srl, 10 = sra, 11 = pass-through.
- `operand`  in  WIDTH  word to shift; latched on accepted start.
- `amount`  in  AMT_W  total shift distance; latched on accepted start.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  WIDTH  final word; held until the next accepted start.
- `sh_data`  out  WIDTH  shifter data input; always equals the internal accumulator.
- `sh_number`  out  3  per-pass shift count to the shifter.
- `sh_sll`, `sh_srl`, `sh_sra`  out  1 each  shifter operation select; one-hot in SHIFT, all 0 otherwise.
- `sh_result`  in  WIDTH  combinational shifter output for the current `sh_data`/`sh_number`/select.

## Operation

- States are IDLE, SHIFT and DONE.
- **IDLE**
  - With `start`=1: latch `acc` ← `operand`, `rem` ← `amount` and `op`.
  - If `amount`=0 or `op`=11, go to DONE. Otherwise go to SHIFT.
- **SHIFT** (one cycle per pass)
  - `step` = min(`rem`, 7). Drive `sh_number`=`step` and the select matching the latched op.
  - At the clock edge: `acc` ← `sh_result` and `rem` ← `rem` − `step`.
  - If the new `rem` is 0, go to DONE. Otherwise stay in SHIFT.
- **DONE**
  - `result` ← `acc` and `done`=1 for this cycle only.
  - Next state is IDLE unconditionally. `start` in DONE is ignored.
- `start` in SHIFT or DONE is ignored. Latched request fields cannot change mid-operation.
- Pass count = ceil(`amount`/7). Every pass except the last uses `step`=7. `rem` never underflows.
- The block performs no arithmetic on data. Fill behaviour (zero fill, or sign fill for sra) is entirely the shifter's responsibility.
- Pass-through (`op`=11) and zero amount never assert any `sh_*` select.

## Timing

- Reset state: IDLE. `acc`, `rem`, `result` = 0. `busy`, `done`, `sh_number`, `sh_sll`, `sh_srl`, `sh_sra` = 0.
- Reset has priority over every transition. Asserting it mid-operation aborts the request with no `done` pulse. A `start` presented in the reset cycle is dropped.
- Let cycle 0 be the edge that accepts `start`:
  - SHIFT occupies cycles 1..P, where P = pass count.
  - DONE and `done` occur in cycle P+1, with `result` valid from that cycle.
  - Zero amount or pass-through gives `done` in cycle 1.
- `busy` rises in cycle 1 and falls in cycle P+2, the first IDLE cycle.
- The next `start` can be accepted at the earliest in cycle P+2. Back-to-back throughput is one request per P+2 cycles.
- `sh_result` must settle within one clock period. There is no registered stage inside the loop besides `acc`.

## Test plan

- sll, `operand`=0x00000001, `amount`=10:
  - Passes carry `sh_number` 7 then 3, with `sh_sll`=1 in cycles 1–2.
  - `done` in cycle 3, `result`=0x00000400.
- sra, `operand`=0x80000000, `amount`=31:
  - `sh_number` sequence is 7,7,7,7,3.
  - `done` in cycle 6, `result`=0xFFFFFFFF. `busy` is high in cycles 1–6.
- srl with the same operand and `amount`=31:
  - `result`=0x00000001, `sh_sra` never asserted.
- `amount`=0 with `op`=00, and separately `op`=11 with `amount`=5, both with `operand`=0xA5A5A5A5:
  - `done` in cycle 1, `result`=0xA5A5A5A5, all `sh_*` selects stay 0.
- Start while busy:
  - Issue sll by 14, then pulse `start` (srl by 3) in cycle 1 and again in the DONE cycle.
  - Both pulses are ignored: a single `done` in cycle 3 with the sll result.
  - A new `start` accepted in cycle 4 completes normally.
- Reset mid-operation:
  - Assert `rst` in cycle 2 of an sra-by-20 request.
  - All outputs go to 0 the following cycle, no `done` ever appears, and the next request behaves normally.
